// File: rtl/seg7_bus_if.sv
// seg7_bus_if: data-memory bus slice seen by the 7-segment scanner.
interface seg7_bus_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemWrite;
  logic        MemRead;
  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped 4-digit 7-segment scanner with hex decode, leading-zero blanking and DP mask.
module seg7_scan_ctrl #(
  parameter int          SCAN_DIV   = 3072,
  parameter logic [31:0] VALUE_ADDR = 32'h4000_0014,
  parameter logic [31:0] CTRL_ADDR  = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  seg7_bus_if.slave   bus,
  output logic [11:0] bcd7
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [15:0]   value;
  logic [7:0]    ctrl;
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic          sel_value, sel_ctrl, en, lzb, blank;
  logic [3:0]    nibble;
  logic [6:0]    hex;
  logic [11:0]   bcd7_next;
  logic          unused_wdata;
  assign sel_value    = bus.Address == VALUE_ADDR;
  assign sel_ctrl     = bus.Address == CTRL_ADDR;
  assign en           = ctrl[0];
  assign lzb          = ctrl[1];
  assign unused_wdata = &{1'b0, bus.WriteData[31:16]};
  always_comb begin
    bus.ReadData = !bus.MemRead ? 32'h0 :
                   sel_value    ? {16'h0, value} :
                   sel_ctrl     ? {24'h0, ctrl} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      ctrl  <= '0;
    end else if (bus.MemWrite) begin
      if (sel_value) value <= bus.WriteData[15:0];
      if (sel_ctrl)  ctrl  <= bus.WriteData[7:0] & 8'hF3;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= '0;
      digit <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt   <= '0;
      digit <= digit + 2'd1;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end
  // A digit is blank when it and every more-significant nibble are zero.
  always_comb begin
    nibble = value[{digit, 2'b00} +: 4];
    blank  = lzb && (digit != 2'd0) && ((value >> {digit, 2'b00}) == 16'h0);
    case (nibble)
      4'h0: hex = 7'h3F;
      4'h1: hex = 7'h06;
      4'h2: hex = 7'h5B;
      4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;
      4'h5: hex = 7'h6D;
      4'h6: hex = 7'h7D;
      4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h6F;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;
      4'hD: hex = 7'h5E;
      4'hE: hex = 7'h79;
      default: hex = 7'h71;
    endcase
    bcd7_next = en ? {4'b0001 << digit, ctrl[{1'b1, digit}], blank ? 7'h00 : hex} : 12'h000;
  end
  always_ff @(posedge clk) begin
    bcd7 <= reset ? 12'h000 : bcd7_next;
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: vector tables, hand sequences and a randomized run against a cycle-level model.
module tb_seg7_scan_ctrl;
  localparam int          DIV = 4;
  localparam logic [31:0] VA  = 32'h4000_0014;
  localparam logic [31:0] CA  = 32'h4000_0018;
  localparam logic [31:0] OA  = 32'h4000_0010;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } bus_vec_t;

  logic        clk = 0;
  logic        reset = 1;
  logic [11:0] bcd7;
  int          nchk = 0;
  int          nfail = 0;
  logic [15:0] m_value;
  logic [7:0]  m_ctrl;
  int          m_phase;
  logic [6:0]  hex_tab [16];
  logic [11:0] scan_exp [4];
  logic [11:0] lzb_a [4];
  logic [11:0] lzb_b [4];
  bus_vec_t    vecs [10];

  seg7_bus_if bus ();
  seg7_scan_ctrl #(.SCAN_DIV(DIV), .VALUE_ADDR(VA), .CTRL_ADDR(CA)) dut (
    .clk(clk), .reset(reset), .bus(bus), .bcd7(bcd7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %0s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Digit on display is purely a function of how long the scan has been running.
  function automatic logic [11:0] model_out();
    int         d;
    logic       blk;
    logic [3:0] nib;
    if (!m_ctrl[0]) return 12'h000;
    d   = (m_phase / DIV) % 4;
    nib = 4'((m_value >> (4 * d)) & 16'hF);
    blk = m_ctrl[1] && d > 0 && (m_value >> (4 * d)) == 0;
    return {4'(1 << d), m_ctrl[4 + d], blk ? 7'h00 : hex_tab[nib]};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr, input logic rd);
    if (!rd) return 32'h0;
    if (addr == VA) return {16'h0, m_value};
    if (addr == CA) return {24'h0, m_ctrl & 8'hF3};
    return 32'h0;
  endfunction

  task automatic tick();
    logic [11:0] e;
    int          nxt;
    e = reset ? 12'h000 : model_out();
    @(posedge clk);
    if (reset) begin
      m_value = 0;
      m_ctrl  = 0;
      m_phase = 0;
    end else begin
      nxt = m_ctrl[0] ? m_phase + 1 : 0;
      if (bus.MemWrite && bus.Address == VA) m_value = bus.WriteData[15:0];
      if (bus.MemWrite && bus.Address == CA) m_ctrl = bus.WriteData[7:0];
      m_phase = nxt;
    end
    #1;
    chk("bcd7_model", {20'h0, bcd7}, {20'h0, e});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1;
    tick();
    bus.MemWrite  = 0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.Address = addr;
    bus.MemRead = 1;
    #1;
    chk(name, bus.ReadData, exp);
    bus.MemRead = 0;
  endtask

  initial begin
    hex_tab  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    scan_exp = '{12'h166, 12'h24F, 12'h45B, 12'h806};
    lzb_a    = '{12'h1BF, 12'h207, 12'h400, 12'h800};
    lzb_b    = '{12'h1BF, 12'h200, 12'h400, 12'h800};
    vecs = '{
      '{1, 0, CA, 32'h0000_00FF, 32'h0},
      '{0, 1, CA, 32'h0,         32'h0000_00F3},
      '{1, 0, VA, 32'hDEAD_BEEF, 32'h0},
      '{0, 1, VA, 32'h0,         32'h0000_BEEF},
      '{1, 0, OA, 32'h0000_1234, 32'h0},
      '{0, 1, VA, 32'h0,         32'h0000_BEEF},
      '{0, 1, CA, 32'h0,         32'h0000_00F3},
      '{0, 1, OA, 32'h0,         32'h0},
      '{1, 1, VA, 32'h0000_5555, 32'h0000_BEEF},
      '{1, 1, CA, 32'h0000_0000, 32'h0000_00F3}
    };
    m_value = 0;
    m_ctrl  = 0;
    m_phase = 0;
    bus.Address   = 0;
    bus.WriteData = 0;
    bus.MemWrite  = 0;
    bus.MemRead   = 0;
    // Reset
    ticks(2);
    chk("rst_bcd7", {20'h0, bcd7}, 32'h0);
    reset = 0;
    rd("rst_rd_value", VA, 32'h0);
    rd("rst_rd_ctrl", CA, 32'h0);
    bus.Address = VA;
    #1;
    chk("rst_rd_idle", bus.ReadData, 32'h0);
    // Bus vector table; combined read+write rows expect the pre-write value
    foreach (vecs[i]) begin
      bus.Address   = vecs[i].addr;
      bus.WriteData = vecs[i].data;
      bus.MemRead   = vecs[i].rd;
      bus.MemWrite  = vecs[i].wr;
      #1;
      if (vecs[i].rd) chk($sformatf("vec%0d_rd", i), bus.ReadData, vecs[i].exp);
      if (vecs[i].wr) tick();
      bus.MemWrite = 0;
      bus.MemRead  = 0;
    end
    rd("vec_after_rw", VA, 32'h0000_5555);
    // Basic scan
    wr(VA, 32'h1234);
    wr(CA, 32'h01);
    for (int k = 0; k < 17; k++) begin
      tick();
      chk($sformatf("scan%0d", k), {20'h0, bcd7}, {20'h0, scan_exp[(k / 4) % 4]});
    end
    // Leading-zero blanking with DP
    wr(CA, 32'h00);
    wr(VA, 32'h0070);
    wr(CA, 32'h13);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("lzb_a%0d", k), {20'h0, bcd7}, {20'h0, lzb_a[k / 4]});
    end
    wr(CA, 32'h00);
    wr(VA, 32'h0000);
    wr(CA, 32'h13);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("lzb_b%0d", k), {20'h0, bcd7}, {20'h0, lzb_b[k / 4]});
    end
    // Disable/re-enable and reset mid-scan
    wr(CA, 32'h00);
    wr(VA, 32'h1234);
    wr(CA, 32'h01);
    ticks(9);
    chk("mid_d2", {20'h0, bcd7}, 32'h45B);
    wr(CA, 32'h00);
    tick();
    chk("mid_dis", {20'h0, bcd7}, 32'h000);
    wr(CA, 32'h01);
    tick();
    chk("mid_reen", {20'h0, bcd7}, 32'h166);
    ticks(12);
    chk("mid_d3", {20'h0, bcd7}, 32'h806);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst", {20'h0, bcd7}, 32'h000);
    rd("mid_rst_value", VA, 32'h0);
    rd("mid_rst_ctrl", CA, 32'h0);
    // Value update mid-digit keeps the scan schedule
    wr(VA, 32'h1234);
    wr(CA, 32'h01);
    tick();
    chk("upd_d0", {20'h0, bcd7}, 32'h166);
    wr(VA, 32'h000F);
    tick();
    chk("upd_next", {20'h0, bcd7}, 32'h171);
    tick();
    tick();
    chk("upd_sched", {20'h0, bcd7}, 32'h23F);
    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      bus.Address   = sel == 0 ? VA : sel == 1 ? CA : sel == 2 ? OA : $urandom;
      bus.WriteData = $urandom;
      if (sel == 1 && $urandom_range(0, 3) != 0) bus.WriteData[0] = 1'b1;
      bus.MemRead  = 1'($urandom_range(0, 1));
      bus.MemWrite = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 199) == 0;
      #1;
      chk("rand_rd", bus.ReadData, model_rd(bus.Address, bus.MemRead));
      tick();
    end
    reset = 0;
    bus.MemWrite = 0;
    bus.MemRead  = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
